bldc_commutation_sequencer: RTL and testbench

Six-step commutation controller for the BLDC drive. Consumes run configuration (en, vel, duty) from the register block and the step period T from the velocity lookup table. Sequences rotor alignment, timed commutation steps, a duty soft-start/soft-stop ramp and fault handling. Produces phase_state, which is fed back to the register block for readback, plus six gate enables and the applied duty for the PWM stage.

---
 rtl/bldc_commutation_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_bldc_commutation_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_commutation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bldc_commutation_sequencer
// Description : Six-step BLDC commutation controller. Aligns the rotor,
//               steps the Hall-style phase code on a programmable period,
//               ramps the applied duty on start/stop and latches faults on
//               an illegal step period.
//               Optional build macro BLDC_DEADTIME_EN inserts an all-gates-off
//               window after every phase advance.
// Revision    : 1.0 - initial release
// ============================================================================
module bldc_commutation_sequencer #(
  parameter int unsigned ALIGN_CYCLES    = 1000,
  parameter int unsigned RAMP_STEP       = 1,
  parameter int unsigned MIN_T           = 2,
  parameter int unsigned DEADTIME_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  vel,
  input  logic [7:0]  duty,
  input  logic        dir,
  input  logic [31:0] T,
  output logic [2:0]  phase_state,
  output logic [5:0]  gates,
  output logic [7:0]  duty_applied,
  output logic        step_tick,
  output logic [2:0]  state,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RUN   = 3'd2,
    S_STOP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [31:0] c_align_load = 32'(ALIGN_CYCLES - 1);
  localparam logic [31:0] c_min_t      = 32'(MIN_T);
  localparam logic [8:0]  c_ramp       = 9'(RAMP_STEP);
  localparam logic [2:0]  c_phase_home = 3'b001;

  // Next Hall code in the six-step cycle; reverse is the exact inverse.
  function automatic logic [2:0] f_next_phase(input logic [2:0] p, input logic d);
    logic [2:0] n;
    n = c_phase_home;
    case (p)
      3'b001:  n = d ? 3'b101 : 3'b011;
      3'b011:  n = d ? 3'b001 : 3'b010;
      3'b010:  n = d ? 3'b011 : 3'b110;
      3'b110:  n = d ? 3'b010 : 3'b100;
      3'b100:  n = d ? 3'b110 : 3'b101;
      3'b101:  n = d ? 3'b100 : 3'b001;
      default: n = c_phase_home;
    endcase
    return n;
  endfunction

  // Switch pattern {AH,AL,BH,BL,CH,CL} for each Hall code.
  function automatic logic [5:0] f_gate_map(input logic [2:0] p);
    logic [5:0] g;
    g = 6'd0;
    case (p)
      3'b001:  g = 6'b100100;
      3'b011:  g = 6'b100001;
      3'b010:  g = 6'b001001;
      3'b110:  g = 6'b011000;
      3'b100:  g = 6'b010010;
      3'b101:  g = 6'b000110;
      default: g = 6'd0;
    endcase
    return g;
  endfunction

  state_t      r_state;
  logic [2:0]  r_phase;
  logic [5:0]  r_gates;
  logic [7:0]  r_duty;
  logic        r_tick;
  logic        r_fault;
  logic [31:0] r_align;
  logic [31:0] r_timer;

  state_t      w_state_nxt;
  logic [2:0]  w_phase_nxt;
  logic [5:0]  w_gates_nxt;
  logic [7:0]  w_duty_nxt;
  logic        w_tick_nxt;
  logic [31:0] w_align_nxt;
  logic [31:0] w_timer_nxt;
  logic        w_advance;
  logic        w_active;
  logic        w_blank;

  logic        w_run;
  logic        w_t_ok;
  logic [31:0] w_t_reload;
  logic [8:0]  w_da9;
  logic [8:0]  w_tgt9;
  logic [8:0]  w_up9;
  logic [7:0]  w_dn8;
  logic [7:0]  w_toward;
  logic [7:0]  w_floor;

  // Run request, period legality and the two duty ramp candidates.
  always_comb begin
    w_run      = en && (vel != 8'd0);
    w_t_ok     = (T >= c_min_t);
    w_t_reload = (T == 32'd0) ? 32'd0 : T - 32'd1;
    w_da9      = {1'b0, r_duty};
    w_tgt9     = {1'b0, duty};
    w_up9      = w_da9 + c_ramp;
    w_dn8      = r_duty - c_ramp[7:0];
    if (w_da9 < w_tgt9) begin
      w_toward = (w_up9 > w_tgt9) ? duty : w_up9[7:0];
    end else if (w_da9 > w_tgt9) begin
      w_toward = ((w_da9 - w_tgt9) <= c_ramp) ? duty : w_dn8;
    end else begin
      w_toward = r_duty;
    end
    w_floor = (w_da9 <= c_ramp) ? 8'd0 : w_dn8;
  end

  // Sequencer next-state logic: alignment, timed stepping, ramping and faults.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_duty_nxt  = r_duty;
    w_tick_nxt  = 1'b0;
    w_align_nxt = r_align;
    w_timer_nxt = r_timer;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_run) begin
          if (w_t_ok) begin
            w_state_nxt = S_ALIGN;
            w_align_nxt = c_align_load;
            w_phase_nxt = c_phase_home;
            w_duty_nxt  = duty >> 2;
          end else begin
            w_state_nxt = S_FAULT;
          end
        end
      end
      S_ALIGN: begin
        if (!w_run || (r_align == 32'd0)) begin
          // Leaving alignment always loads the step timer, so T is checked here.
          if (!w_t_ok) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_timer_nxt = w_t_reload;
            if (w_run) begin
              w_state_nxt = S_RUN;
              w_duty_nxt  = 8'd0;
            end else begin
              w_state_nxt = S_STOP;
            end
          end
        end else begin
          w_align_nxt = r_align - 32'd1;
        end
      end
      S_RUN, S_STOP: begin
        if (r_timer == 32'd0) begin
          if (w_t_ok) begin
            w_advance   = 1'b1;
            w_tick_nxt  = 1'b1;
            w_phase_nxt = f_next_phase(r_phase, dir);
            w_timer_nxt = w_t_reload;
          end
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
        if ((r_timer == 32'd0) && !w_t_ok) begin
          w_state_nxt = S_FAULT;
        end else if ((r_state == S_RUN) || w_run) begin
          // A reasserted request in STOP resumes RUN with timer and ramp intact.
          if (w_advance) begin
            w_duty_nxt = w_toward;
          end
          w_state_nxt = w_run ? S_RUN : S_STOP;
        end else begin
          w_duty_nxt = w_floor;
          if (w_floor == 8'd0) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_FAULT: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_state_nxt == S_FAULT) begin
      w_duty_nxt = 8'd0;
    end
    w_active = (w_state_nxt == S_ALIGN) || (w_state_nxt == S_RUN) ||
               (w_state_nxt == S_STOP);
  end

`ifdef BLDC_DEADTIME_EN
  localparam logic [15:0] c_dt_load = 16'(DEADTIME_CYCLES - 1);

  logic [15:0] r_dt;
  logic [15:0] w_dt_nxt;

  // Blank the bridge on the advance cycle and for the remaining window after it.
  always_comb begin
    w_dt_nxt = 16'd0;
    w_blank  = 1'b0;
    if (w_active) begin
      if (w_advance) begin
        w_dt_nxt = c_dt_load;
        w_blank  = 1'b1;
      end else if (r_dt != 16'd0) begin
        w_dt_nxt = r_dt - 16'd1;
        w_blank  = 1'b1;
      end
    end
  end

  // Dead-time window counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dt <= 16'd0;
    end else begin
      r_dt <= w_dt_nxt;
    end
  end
`else
  logic w_dt_unused;
  assign w_blank     = 1'b0;
  assign w_dt_unused = (DEADTIME_CYCLES != 0);
`endif

  assign w_gates_nxt = (w_active && !w_blank) ? f_gate_map(w_phase_nxt) : 6'd0;

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_phase <= c_phase_home;
      r_gates <= 6'd0;
      r_duty  <= 8'd0;
      r_tick  <= 1'b0;
      r_fault <= 1'b0;
      r_align <= 32'd0;
      r_timer <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_gates <= w_gates_nxt;
      r_duty  <= w_duty_nxt;
      r_tick  <= w_tick_nxt;
      r_fault <= (w_state_nxt == S_FAULT);
      r_align <= w_align_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  assign phase_state  = r_phase;
  assign gates        = r_gates;
  assign duty_applied = r_duty;
  assign step_tick    = r_tick;
  assign state        = r_state;
  assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_bldc_commutation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bldc_commutation_sequencer
// Description : Self-checking bench for bldc_commutation_sequencer. Directed
//               scenarios followed by randomized inputs, all compared each
//               cycle against a behavioural model of the commutation rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bldc_commutation_sequencer;

  localparam int P_ALIGN = 8;
  localparam int P_RAMP  = 16;
  localparam int P_MIN_T = 2;
  localparam int P_DT    = 4;

  localparam int S_IDLE  = 0;
  localparam int S_ALIGN = 1;
  localparam int S_RUN   = 2;
  localparam int S_STOP  = 3;
  localparam int S_FAULT = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  vel;
  logic [7:0]  duty;
  logic        dir;
  logic [31:0] T;
  logic [2:0]  phase_state;
  logic [5:0]  gates;
  logic [7:0]  duty_applied;
  logic        step_tick;
  logic [2:0]  state;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: phase is an index into the forward rotation 0..5.
  int m_state, m_idx, m_duty, m_tick, m_fault, m_align, m_timer, m_blank, m_gates;

  bldc_commutation_sequencer #(
    .ALIGN_CYCLES    (P_ALIGN),
    .RAMP_STEP       (P_RAMP),
    .MIN_T           (P_MIN_T),
    .DEADTIME_CYCLES (P_DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .vel          (vel),
    .duty         (duty),
    .dir          (dir),
    .T            (T),
    .phase_state  (phase_state),
    .gates        (gates),
    .duty_applied (duty_applied),
    .step_tick    (step_tick),
    .state        (state),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] seq_code(input int i);
    case (i)
      0: return 3'b001;
      1: return 3'b011;
      2: return 3'b010;
      3: return 3'b110;
      4: return 3'b100;
      default: return 3'b101;
    endcase
  endfunction

  function automatic logic [5:0] gate_code(input int i);
    case (i)
      0: return 6'b100100;
      1: return 6'b100001;
      2: return 6'b001001;
      3: return 6'b011000;
      4: return 6'b010010;
      default: return 6'b000110;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_idx = 0; m_duty = 0; m_tick = 0; m_fault = 0;
    m_align = 0; m_timer = 0; m_blank = 0; m_gates = 0;
  endtask

  task automatic model_step();
    bit run, adv, flt, active;
    int t, d;
    run = en && (vel != 8'd0);
    t   = int'(T);
    d   = int'(duty);
    adv = 0; flt = 0;
    m_tick = 0;
    case (m_state)
      S_IDLE: if (run) begin
        if (t >= P_MIN_T) begin
          m_state = S_ALIGN; m_align = P_ALIGN - 1; m_idx = 0; m_duty = d / 4;
        end else m_state = S_FAULT;
      end
      S_ALIGN: begin
        if (!run || m_align == 0) begin
          if (t < P_MIN_T) m_state = S_FAULT;
          else begin
            m_timer = t - 1;
            if (run) begin m_state = S_RUN; m_duty = 0; end
            else m_state = S_STOP;
          end
        end else m_align = m_align - 1;
      end
      S_RUN, S_STOP: begin
        if (m_timer == 0) begin
          if (t < P_MIN_T) flt = 1;
          else begin
            adv = 1; m_tick = 1; m_timer = t - 1;
            m_idx = dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
          end
        end else m_timer = m_timer - 1;
        if (flt) m_state = S_FAULT;
        else if (m_state == S_RUN || run) begin
          if (adv) begin
            if (m_duty < d) m_duty = (m_duty + P_RAMP > d) ? d : m_duty + P_RAMP;
            else            m_duty = (m_duty - P_RAMP < d) ? d : m_duty - P_RAMP;
          end
          m_state = run ? S_RUN : S_STOP;
        end else begin
          m_duty = (m_duty - P_RAMP < 0) ? 0 : m_duty - P_RAMP;
          if (m_duty == 0) m_state = S_IDLE;
        end
      end
      default: if (!en) m_state = S_IDLE;
    endcase
    if (m_state == S_FAULT) m_duty = 0;
    m_fault = (m_state == S_FAULT) ? 1 : 0;
    active  = (m_state == S_ALIGN) || (m_state == S_RUN) || (m_state == S_STOP);
`ifdef BLDC_DEADTIME_EN
    if (!active) m_blank = 0;
    else if (adv) m_blank = P_DT;
    else if (m_blank > 0) m_blank = m_blank - 1;
`endif
    m_gates = (active && m_blank == 0) ? int'(gate_code(m_idx)) : 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (!rst) model_reset();
    else model_step();
    check_val("state", state, m_state);
    check_val("phase_state", phase_state, seq_code(m_idx));
    check_val("gates", gates, m_gates);
    check_val("duty_applied", duty_applied, m_duty);
    check_val("step_tick", step_tick, m_tick);
    check_val("fault", fault, m_fault);
  endtask

  task automatic wait_tick(input string tag, input int budget, output int waited);
    waited = 0;
    do begin
      cycle();
      waited++;
    end while (step_tick !== 1'b1 && waited < budget);
    check_val(tag, step_tick, 1);
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    int k;
    k = 0;
    while (int'(state) != s && k < budget) begin
      cycle();
      k++;
    end
    check_val(tag, state, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, " state"}, state, S_IDLE);
    check_val({tag, " phase"}, phase_state, 3'b001);
    check_val({tag, " gates"}, gates, 0);
    check_val({tag, " duty"}, duty_applied, 0);
    check_val({tag, " tick"}, step_tick, 0);
    check_val({tag, " fault"}, fault, 0);
  endtask

  initial begin : main
    int n, w, z;
    logic [17:0] fwd_exp;
    logic [17:0] rev_exp;
    logic [35:0] rev_gates;
    fwd_exp   = {3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    rev_exp   = {3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    rev_gates = {6'b000110, 6'b010010, 6'b011000, 6'b001001, 6'b100001, 6'b100100};

    rst = 1'b0; en = 1'b0; vel = 8'd0; duty = 8'd0; dir = 1'b0; T = 32'd20;
    model_reset();
    repeat (3) cycle();
    check_reset_outputs("reset");
    rst = 1'b1;

    // Forward stepping after alignment.
    en = 1'b1; vel = 8'd3; duty = 8'd128; T = 32'd20; dir = 1'b0;
    cycle();
    check_val("t1 align state", state, S_ALIGN);
    check_val("t1 align gates", gates, 6'b100100);
    check_val("t1 align duty", duty_applied, 32);
    n = 1;
    while (int'(state) == S_ALIGN && n < 50) begin
      cycle();
      n++;
    end
    check_val("t1 align length", n - 1, P_ALIGN);
    for (int i = 0; i < 6; i++) begin
      wait_tick("t1 tick", 40, w);
      check_val("t1 fwd phase", phase_state, fwd_exp[17 - 3*i -: 3]);
      if (i > 0) check_val("t1 tick period", w, 20);
    end

    // Reverse stepping with per-state gate pattern.
    dir = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_tick("t2 tick", 40, w);
      check_val("t2 rev phase", phase_state, rev_exp[17 - 3*i -: 3]);
`ifdef BLDC_DEADTIME_EN
      z = 0;
      while (gates == 6'd0 && z < 30) begin
        cycle();
        z++;
      end
      check_val("t2 deadtime length", z, P_DT);
`endif
      check_val("t2 rev gates", gates, rev_gates[35 - 6*i -: 6]);
    end

    // Ramp up in RUN steps, then ramp down to a lower target.
    en = 1'b0;
    wait_state("t3 idle", S_IDLE, 40);
    duty = 8'd64; en = 1'b1;
    wait_state("t3 run", S_RUN, 30);
    check_val("t3 run start duty", duty_applied, 0);
    for (int i = 0; i < 5; i++) begin
      wait_tick("t3 tick", 40, w);
      check_val("t3 ramp up", duty_applied, (i < 4) ? (i + 1) * P_RAMP : 64);
    end
    duty = 8'd40;
    wait_tick("t3 tick", 40, w);
    check_val("t3 ramp down 1", duty_applied, 48);
    wait_tick("t3 tick", 40, w);
    check_val("t3 ramp down 2", duty_applied, 40);

    // Soft stop to IDLE, then a resume from the middle of STOP.
    duty = 8'd64;
    wait_tick("t4 tick", 40, w);
    check_val("t4 ramp 56", duty_applied, 56);
    wait_tick("t4 tick", 40, w);
    check_val("t4 ramp 64", duty_applied, 64);
    en = 1'b0;
    cycle();
    check_val("t4 stop entry", state, S_STOP);
    check_val("t4 stop duty", duty_applied, 64);
    n = 1;
    while (int'(state) == S_STOP && n < 20) begin
      cycle();
      n++;
    end
    check_val("t4 stop length", n - 1, 4);
    check_val("t4 idle state", state, S_IDLE);
    check_val("t4 idle gates", gates, 0);
    en = 1'b1;
    wait_state("t4 rerun", S_RUN, 30);
    for (int i = 0; i < 4; i++) wait_tick("t4 tick", 40, w);
    check_val("t4 duty before drop", duty_applied, 64);
    en = 1'b0;
    n = 0;
    while (duty_applied != 8'd32 && n < 10) begin
      cycle();
      n++;
    end
    check_val("t4 mid-stop state", state, S_STOP);
    check_val("t4 mid-stop duty", duty_applied, 32);
    en = 1'b1;
    cycle();
    check_val("t4 resume state", state, S_RUN);
    check_val("t4 resume duty", duty_applied, 32);

    // Illegal period on reload latches a fault until en drops.
    T = 32'd1;
    wait_state("t5 fault", S_FAULT, 40);
    check_val("t5 fault flag", fault, 1);
    check_val("t5 fault gates", gates, 0);
    check_val("t5 fault duty", duty_applied, 0);
    repeat (10) cycle();
    check_val("t5 fault held", state, S_FAULT);
    check_val("t5 fault flag held", fault, 1);
    en = 1'b0;
    cycle();
    check_val("t5 cleared state", state, S_IDLE);
    check_val("t5 cleared flag", fault, 0);

    // Asynchronous reset between edges while running.
    T = 32'd5; en = 1'b1;
    wait_state("t6 run", S_RUN, 30);
    repeat (7) cycle();
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("t6 async");
    model_reset();
    cycle();
    cycle();
    rst = 1'b1;

    // Randomized operation against the model.
    en = 1'b0; vel = 8'd5; duty = 8'd100; T = 32'd6;
    for (int it = 0; it < 3000; it++) begin
      rst = 1'b1;
      if ($urandom_range(0, 99) < 3) en = ~en;
      if ($urandom_range(0, 99) < 2)
        vel = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 99) < 5) duty = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 99) < 4)
        T = ($urandom_range(0, 99) < 8) ? 32'($urandom_range(0, 1)) : 32'($urandom_range(2, 12));
      dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) < 2) begin
        #3 rst = 1'b0;
        #1;
        check_reset_outputs("rnd async");
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
